// File: rtl/pr_pkg.sv
// Shared constants, loader state encoding and flat-array index helpers used by
// the graph loader, the page-rank engines and the sorter.
package pr_pkg;
  localparam int N     = 64;
  localparam int WIDTH = 16;
  localparam int ID_W  = 6;
  localparam logic [WIDTH-1:0] INIT_WEIGHT = 16'd1024;

  localparam int OD_W      = ID_W + 1;
  localparam int ADJ_W     = N * N;
  localparam int WT_W      = N * WIDTH;
  localparam int DEG_W     = N * OD_W;
  localparam int ADJ_IDX_W = $clog2(ADJ_W);
  localparam int WT_IDX_W  = $clog2(WT_W);
  localparam int DEG_IDX_W = $clog2(DEG_W);

  localparam logic REC_EDGE   = 1'b0;
  localparam logic REC_WEIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
  } ld_state_e;

  // N and WIDTH are powers of two, so src*N+dst and id*WIDTH are concatenations.
  function automatic logic [ADJ_IDX_W-1:0] adj_idx(input logic [ID_W-1:0] src,
                                                   input logic [ID_W-1:0] dst);
    return {src, dst};
  endfunction

  function automatic logic [WT_IDX_W-1:0] wt_base(input logic [ID_W-1:0] id);
    return {id, {$clog2(WIDTH){1'b0}}};
  endfunction

  function automatic logic [DEG_IDX_W-1:0] deg_base(input logic [ID_W-1:0] id);
    return DEG_IDX_W'(id) * DEG_IDX_W'(OD_W);
  endfunction
endpackage

// File: rtl/graph_loader_row_popcount.sv
// Combinational population count of one adjacency row.
module row_popcount #(
  parameter int W  = 64,
  parameter int CW = 7
) (
  input  logic [W-1:0]  row_i,
  output logic [CW-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(row_i[i]);
  end
endmodule

// File: rtl/graph_loader.sv
// Builds the adjacency matrix and weight vector from a record stream, then scans
// each row for out-degree and dangling-node count before releasing the engine.
module graph_loader
  import pr_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_type,
  input  logic [ID_W-1:0]      in_src,
  input  logic [ID_W-1:0]      in_dst,
  input  logic [WIDTH-1:0]     in_weight,
  input  logic                 in_last,
  output logic [ADJ_W-1:0]     adjacency,
  output logic [WT_W-1:0]      weights,
  output logic [DEG_W-1:0]     out_degree,
  output logic [OD_W-1:0]      dangling_cnt,
  output logic [7:0]           self_loop_drops,
  output logic                 busy,
  output logic                 graph_valid
);
  ld_state_e        state_q;
  logic [ID_W-1:0]  row_q;
  logic [ADJ_W-1:0] adj_q;
  logic [WT_W-1:0]  wt_q;
  logic [DEG_W-1:0] deg_q;
  logic [OD_W-1:0]  dang_q;
  logic [7:0]       sld_q;
  logic             busy_q, gv_q, rdy_q;
  logic [OD_W-1:0]  row_cnt;

  row_popcount #(.W(N), .CW(OD_W)) u_pop (
    .row_i (adj_q[adj_idx(row_q, '0) +: N]),
    .cnt_o (row_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      adj_q   <= '0;
      wt_q    <= '0;
      deg_q   <= '0;
      dang_q  <= '0;
      sld_q   <= '0;
      busy_q  <= 1'b0;
      gv_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          adj_q   <= '0;
          wt_q    <= {N{INIT_WEIGHT}};
          deg_q   <= '0;
          dang_q  <= '0;
          sld_q   <= '0;
          gv_q    <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (in_valid && rdy_q) begin
            if (in_type == REC_EDGE) begin
              if (in_src != in_dst) adj_q[adj_idx(in_src, in_dst)] <= 1'b1;
              else if (sld_q != 8'hFF) sld_q <= sld_q + 8'd1;
            end else begin
              wt_q[wt_base(in_src) +: WIDTH] <= in_weight;
            end
            if (in_last) begin
              state_q <= ST_SCAN;
              rdy_q   <= 1'b0;
              row_q   <= '0;
            end
          end
        end
        ST_SCAN: begin
          deg_q[deg_base(row_q) +: OD_W] <= row_cnt;
          if (row_cnt == '0) dang_q <= dang_q + OD_W'(1);
          if (row_q == ID_W'(N - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
          end else begin
            row_q <= row_q + ID_W'(1);
          end
        end
        ST_DONE: begin
          // graph_valid rises one cycle after entering DONE and drops on start.
          if (start) begin
            state_q <= ST_CLEAR;
            gv_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            gv_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready        = rdy_q;
  assign adjacency       = adj_q;
  assign weights         = wt_q;
  assign out_degree      = deg_q;
  assign dangling_cnt    = dang_q;
  assign self_loop_drops = sld_q;
  assign busy            = busy_q;
  assign graph_valid     = gv_q;
endmodule

// File: tb/tb_graph_loader.sv
// Directed self-checking bench for graph_loader: load, scan timing, backpressure,
// clear-on-restart and mid-load reset.
module tb_graph_loader;
  import pr_pkg::*;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, in_type, in_last;
  logic [ID_W-1:0]  in_src, in_dst;
  logic [WIDTH-1:0] in_weight;
  logic             in_ready, busy, graph_valid;
  logic [ADJ_W-1:0] adjacency;
  logic [WT_W-1:0]  weights;
  logic [DEG_W-1:0] out_degree;
  logic [OD_W-1:0]  dangling_cnt;
  logic [7:0]       self_loop_drops;

  int cmps = 0;
  int errs = 0;

  graph_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_src(in_src), .in_dst(in_dst), .in_weight(in_weight),
    .in_last(in_last), .adjacency(adjacency), .weights(weights), .out_degree(out_degree),
    .dangling_cnt(dangling_cnt), .self_loop_drops(self_loop_drops), .busy(busy),
    .graph_valid(graph_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] deg(input int i);
    return 64'(out_degree[i*OD_W +: OD_W]);
  endfunction

  function automatic logic [63:0] wt(input int i);
    return 64'(weights[i*WIDTH +: WIDTH]);
  endfunction

  task automatic send(input logic typ, input int s, input int d, input int w, input logic last);
    chk("in_ready_load", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_type   = typ;
    in_src    = ID_W'(s);
    in_dst    = ID_W'(d);
    in_weight = WIDTH'(w);
    in_last   = last;
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  // Ticks until graph_valid, optionally pulsing start at cycle pulse_at; n = cycles seen.
  task automatic run_to_done(input int pulse_at, output int n);
    n = 0;
    for (int k = 1; k <= 200; k++) begin
      start = (k == pulse_at);
      tick();
      if (graph_valid) begin
        n = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic begin_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    int n, bad;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_type = REC_EDGE;
    in_src = '0; in_dst = '0; in_weight = '0; in_last = 1'b0;
    tick(); tick();
    chk("rst_adj",   64'($countones(adjacency)), 64'd0);
    chk("rst_wt",    64'($countones(weights)), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_rdy",   64'(in_ready), 64'd0);
    chk("rst_gv",    64'(graph_valid), 64'd0);
    chk("rst_dang",  64'(dangling_cnt), 64'd0);
    reset = 1'b1;
    tick();
    chk("idle_rdy", 64'(in_ready), 64'd0);

    // Single edge 3->5
    start = 1'b1; tick(); start = 1'b0;
    chk("clear_busy", 64'(busy), 64'd1);
    chk("clear_rdy",  64'(in_ready), 64'd0);
    tick(); tick(); tick();
    chk("load_rdy",   64'(in_ready), 64'd1);
    chk("load_wt0",   wt(0), 64'd1024);
    chk("load_gv",    64'(graph_valid), 64'd0);
    send(REC_EDGE, 3, 5, 0, 1'b1);
    chk("scan_rdy",   64'(in_ready), 64'd0);
    run_to_done(0, n);
    chk("t1_latency", 64'(n), 64'd65);
    chk("t1_bit",     64'(adjacency[3*64+5]), 64'd1);
    chk("t1_ones",    64'($countones(adjacency)), 64'd1);
    chk("t1_deg3",    deg(3), 64'd1);
    chk("t1_deg5",    deg(5), 64'd0);
    chk("t1_dang",    64'(dangling_cnt), 64'd63);
    chk("t1_busy",    64'(busy), 64'd0);

    // Duplicates, self-loop, in_valid held during SCAN, start during SCAN ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_gv", 64'(graph_valid), 64'd0);
    tick();
    chk("t2_cleared", 64'($countones(adjacency)), 64'd0);
    send(REC_EDGE, 0, 1, 0, 1'b0);
    send(REC_EDGE, 0, 2, 0, 1'b0);
    send(REC_EDGE, 0, 1, 0, 1'b0);
    send(REC_EDGE, 7, 7, 0, 1'b1);
    in_valid = 1'b1; in_type = REC_EDGE; in_src = 6'd9; in_dst = 6'd8;
    run_to_done(10, n);
    tick(); tick();
    in_valid = 1'b0;
    chk("t2_latency", 64'(n), 64'd65);
    chk("t2_deg0",    deg(0), 64'd2);
    chk("t2_self",    64'(adjacency[7*64+7]), 64'd0);
    chk("t2_ones",    64'($countones(adjacency)), 64'd2);
    chk("t2_bp_edge", 64'(adjacency[9*64+8]), 64'd0);
    chk("t2_sld",     64'(self_loop_drops), 64'd1);
    chk("t2_dang",    64'(dangling_cnt), 64'd63);
    chk("t2_gv_hold", 64'(graph_valid), 64'd1);

    // Weight overwrite, weight record held high during SCAN/DONE
    begin_load();
    send(REC_WEIGHT, 10, 0, 16'h4000, 1'b0);
    send(REC_WEIGHT, 10, 0, 16'h0200, 1'b1);
    in_valid = 1'b1; in_type = REC_WEIGHT; in_src = 6'd11; in_weight = 16'hBEEF;
    run_to_done(0, n);
    tick();
    in_valid = 1'b0;
    chk("t3_latency", 64'(n), 64'd65);
    chk("t3_wt10",    wt(10), 64'h200);
    chk("t3_wt11",    wt(11), 64'd1024);
    bad = 0;
    for (int i = 0; i < N; i++) if (i != 10 && wt(i) != 64'd1024) bad++;
    chk("t3_wt_rest", 64'(bad), 64'd0);
    chk("t3_sld_clr", 64'(self_loop_drops), 64'd0);
    chk("t3_dang",    64'(dangling_cnt), 64'd64);

    // Complete graph
    begin_load();
    for (int s = 0; s < N; s++)
      for (int d = 0; d < N; d++)
        if (s != d) send(REC_EDGE, s, d, 0, (s == N-1 && d == N-2));
    run_to_done(0, n);
    chk("t4_latency", 64'(n), 64'd65);
    chk("t4_ones",    64'($countones(adjacency)), 64'd4032);
    bad = 0;
    for (int i = 0; i < N; i++) if (deg(i) != 64'd63) bad++;
    chk("t4_deg_all", 64'(bad), 64'd0);
    chk("t4_dang",    64'(dangling_cnt), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t4_gv_drop", 64'(graph_valid), 64'd0);
    tick();
    chk("t4_adj_clr", 64'($countones(adjacency)), 64'd0);
    chk("t4_deg_clr", 64'($countones(out_degree)), 64'd0);
    chk("t4_rdy",     64'(in_ready), 64'd1);

    // Reset mid-load, then fresh load
    for (int i = 0; i < 10; i++) send(REC_EDGE, i, i + 1, 0, 1'b0);
    chk("t5_partial", 64'($countones(adjacency)), 64'd10);
    reset = 1'b0; tick(); reset = 1'b1;
    chk("t5_rst_adj",  64'($countones(adjacency)), 64'd0);
    chk("t5_rst_wt",   64'($countones(weights)), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_rdy",  64'(in_ready), 64'd0);
    tick();
    chk("t5_idle_rdy", 64'(in_ready), 64'd0);
    begin_load();
    send(REC_EDGE, 3, 5, 0, 1'b1);
    run_to_done(0, n);
    chk("t5_latency", 64'(n), 64'd65);
    chk("t5_ones",    64'($countones(adjacency)), 64'd1);
    chk("t5_deg3",    deg(3), 64'd1);
    chk("t5_dang",    64'(dangling_cnt), 64'd63);
    chk("t5_wt0",     wt(0), 64'd1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
